mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-port memory.
// master: requesters plus memory read data; slave: the arbiter itself.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_func3;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_func3;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_func3, mem_rdata,
    input  if_valid, if_rdata, d_valid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_func3, stall
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_func3, mem_rdata,
    output if_valid, if_rdata, d_valid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_func3, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single-port memory; one access per 2 cycles.
// Define ARB_RR_EN for round-robin arbitration; otherwise data always wins on contention.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE_IF, ISSUE_D, RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [2:0]        func3_q, func3_d;
  logic              gnt_data_q, gnt_data_d;

  logic              if_pend;
  logic              d_pend;
  logic              pick_data;

`ifdef ARB_RR_EN
  // 1 = data was granted last; resets to fetch so the first contention goes to data.
  logic              last_grant_q, last_grant_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    func3_d    = func3_q;
    gnt_data_d = gnt_data_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    // The requester answered in RESP still has req high; it is already consumed.
    if_pend = bus.if_req & ~((state_q == RESP) & ~gnt_data_q);
    d_pend  = bus.d_req  & ~((state_q == RESP) &  gnt_data_q);

`ifdef ARB_RR_EN
    pick_data = d_pend & (~if_pend | ~last_grant_q);
`else
    pick_data = d_pend;
`endif

    case (state_q)
      IDLE, RESP: begin
        if (if_pend | d_pend) begin
          gnt_data_d = pick_data;
`ifdef ARB_RR_EN
          last_grant_d = pick_data;
`endif
          if (pick_data) begin
            state_d = ISSUE_D;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            we_d    = bus.d_we;
            func3_d = bus.d_func3;
          end else begin
            state_d = ISSUE_IF;
            addr_d  = bus.if_addr;
            wdata_d = '0;
            we_d    = 1'b0;
            func3_d = 3'b010;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE_IF, ISSUE_D: state_d = RESP;
      default:           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      func3_q    <= '0;
      gnt_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      func3_q    <= func3_d;
      gnt_data_q <= gnt_data_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b0;
    else     last_grant_q <= last_grant_d;
  end
`endif

  logic              issue;
  logic              if_valid;
  logic              d_valid;
  logic [DATA_W-1:0] if_rdata;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_func3;

  // Memory port driven purely from latched fields; rst kills en/we in the same cycle.
  always_comb begin
    issue     = (state_q == ISSUE_IF) | (state_q == ISSUE_D);
    if_valid  = 1'b0;
    d_valid   = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_func3 = '0;
    mem_en    = issue & ~rst;
    mem_we    = (state_q == ISSUE_D) & we_q & ~rst;
    if (issue) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_func3 = func3_q;
    end
    if (state_q == RESP) begin
      if (gnt_data_q) begin
        d_valid = 1'b1;
        if (!we_q) d_rdata = bus.mem_rdata;
      end else begin
        if_valid = 1'b1;
        if_rdata = bus.mem_rdata;
      end
    end
  end

  assign bus.if_valid  = if_valid;
  assign bus.if_rdata  = if_rdata;
  assign bus.d_valid   = d_valid;
  assign bus.d_rdata   = d_rdata;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_func3 = mem_func3;
  assign bus.stall     = (bus.if_req & ~if_valid) | (bus.d_req & ~d_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized requesters
// checked against a transaction-level memory model.
module tb_mem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory with a backdoor port for preloading.
  logic [DATA_W-1:0] mem_array [0:63];
  logic              bd_we;
  logic [5:0]        bd_idx;
  logic [DATA_W-1:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) mem_array[bd_idx] <= bd_data;
    else if (bus.mem_we) mem_array[bus.mem_addr[7:2]] <= bus.mem_wdata;
    bus.mem_rdata <= bus.mem_en ? mem_array[bus.mem_addr[7:2]] : '0;
  end

  logic [DATA_W-1:0] ref_mem [0:63];
  int vectors = 0;
  int miscompares = 0;
  logic exp_first_data;
  logic if_busy, d_busy, if_done, d_done, d_w;
  int if_age, d_age;
  logic [7:0] if_a, d_a;
  logic [31:0] d_wd;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, ".mem_en"},    32'(bus.mem_en), 0);
    checkOutput({tag, ".mem_we"},    32'(bus.mem_we), 0);
    checkOutput({tag, ".mem_addr"},  32'(bus.mem_addr), 0);
    checkOutput({tag, ".mem_wdata"}, bus.mem_wdata, 0);
    checkOutput({tag, ".mem_func3"}, 32'(bus.mem_func3), 0);
    checkOutput({tag, ".if_valid"},  32'(bus.if_valid), 0);
    checkOutput({tag, ".d_valid"},   32'(bus.d_valid), 0);
    checkOutput({tag, ".if_rdata"},  bus.if_rdata, 0);
    checkOutput({tag, ".d_rdata"},   bus.d_rdata, 0);
  endtask

  task automatic setData(input logic req, input logic we, input logic [7:0] addr, input logic [31:0] wdata);
    bus.d_req   = req;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_func3 = 3'b010;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    setData(1'b0, 1'b0, 8'h00, 32'h0);

    // Preload memory under reset; words 4 (0x10) and 12 (0x30) carry known values.
    for (int i = 0; i < 64; i++) begin
      applyStimulus();
      bd_we   = 1'b1;
      bd_idx  = 6'(i);
      bd_data = (i == 4) ? 32'h00500093 : (i == 12) ? 32'hCAFEF00D : 32'h0;
      ref_mem[i] = bd_data;
    end
    @(negedge clk);
    checkOutput("in_reset.mem_en", 32'(bus.mem_en), 0);

    applyStimulus(); bd_we = 1'b0; rst = 1'b0;
    @(negedge clk);
    checkQuiet("post_reset");
    checkOutput("post_reset.stall", 32'(bus.stall), 0);

    // Single fetch from idle: issue at N+1, valid at N+2.
    applyStimulus(); bus.if_req = 1'b1; bus.if_addr = 8'h10;
    @(negedge clk);
    checkOutput("fetch.n.mem_en", 32'(bus.mem_en), 0);
    checkOutput("fetch.n.stall", 32'(bus.stall), 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("fetch.n1.mem_en", 32'(bus.mem_en), 1);
    checkOutput("fetch.n1.mem_we", 32'(bus.mem_we), 0);
    checkOutput("fetch.n1.mem_addr", 32'(bus.mem_addr), 32'h10);
    checkOutput("fetch.n1.mem_func3", 32'(bus.mem_func3), 2);
    applyStimulus();
    @(negedge clk);
    checkOutput("fetch.n2.if_valid", 32'(bus.if_valid), 1);
    checkOutput("fetch.n2.if_rdata", bus.if_rdata, 32'h00500093);
    checkOutput("fetch.n2.d_valid", 32'(bus.d_valid), 0);
    checkOutput("fetch.n2.stall", 32'(bus.stall), 0);
    checkOutput("fetch.n2.mem_en", 32'(bus.mem_en), 0);
    applyStimulus(); bus.if_req = 1'b0;
    @(negedge clk);
    checkQuiet("fetch.n3");

    // Write then read back the same word.
    applyStimulus(); setData(1'b1, 1'b1, 8'h20, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("wr.n.mem_we", 32'(bus.mem_we), 0);
    applyStimulus();
    @(negedge clk);
    checkOutput("wr.n1.mem_en", 32'(bus.mem_en), 1);
    checkOutput("wr.n1.mem_we", 32'(bus.mem_we), 1);
    checkOutput("wr.n1.mem_addr", 32'(bus.mem_addr), 32'h20);
    checkOutput("wr.n1.mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    applyStimulus();
    @(negedge clk);
    checkOutput("wr.n2.d_valid", 32'(bus.d_valid), 1);
    checkOutput("wr.n2.d_rdata", bus.d_rdata, 0);
    checkOutput("wr.n2.mem_we", 32'(bus.mem_we), 0);
    ref_mem[8] = 32'hDEADBEEF;
    applyStimulus(); bus.d_we = 1'b0;
    @(negedge clk);
    checkOutput("rd.n.d_valid", 32'(bus.d_valid), 0);
    checkOutput("rd.n.mem_en", 32'(bus.mem_en), 0);
    applyStimulus();
    @(negedge clk);
    checkOutput("rd.n1.mem_en", 32'(bus.mem_en), 1);
    checkOutput("rd.n1.mem_we", 32'(bus.mem_we), 0);
    applyStimulus();
    @(negedge clk);
    checkOutput("rd.n2.d_valid", 32'(bus.d_valid), 1);
    checkOutput("rd.n2.d_rdata", bus.d_rdata, ref_mem[8]);
    applyStimulus(); bus.d_req = 1'b0;

    // Both held: D, IF, D, IF with stall high throughout.
    applyStimulus();
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    setData(1'b1, 1'b0, 8'h20, 32'h0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) applyStimulus();
      @(negedge clk);
      checkOutput("both.stall", 32'(bus.stall), 1);
      checkOutput("both.d_valid", 32'(bus.d_valid), 32'((k == 2) || (k == 6)));
      checkOutput("both.if_valid", 32'(bus.if_valid), 32'((k == 4) || (k == 8)));
    end
    applyStimulus(); bus.if_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    checkOutput("both.tail.mem_en", 32'(bus.mem_en), 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("both.tail.d_valid", 32'(bus.d_valid), 1);
    checkOutput("both.tail.d_rdata", bus.d_rdata, ref_mem[8]);
    applyStimulus();
    @(negedge clk);
    checkQuiet("both.idle");

    // Contention from idle right after a data grant: policy decides the winner.
`ifdef ARB_RR_EN
    exp_first_data = 1'b0;
`else
    exp_first_data = 1'b1;
`endif
    applyStimulus();
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    setData(1'b1, 1'b0, 8'h20, 32'h0);
    applyStimulus();
    applyStimulus();
    @(negedge clk);
    checkOutput("policy.d_valid", 32'(bus.d_valid), 32'(exp_first_data));
    checkOutput("policy.if_valid", 32'(bus.if_valid), 32'(!exp_first_data));
    applyStimulus();
    if (exp_first_data) bus.d_req = 1'b0; else bus.if_req = 1'b0;
    @(negedge clk);
    checkOutput("policy.loser.mem_en", 32'(bus.mem_en), 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("policy.loser.d_valid", 32'(bus.d_valid), 32'(!exp_first_data));
    checkOutput("policy.loser.if_valid", 32'(bus.if_valid), 32'(exp_first_data));
    applyStimulus(); bus.if_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    checkOutput("policy.idle.mem_en", 32'(bus.mem_en), 0);

    // Address change during ISSUE_D is ignored.
    applyStimulus(); setData(1'b1, 1'b0, 8'h20, 32'h0);
    applyStimulus(); bus.d_addr = 8'h40;
    @(negedge clk);
    checkOutput("hold.mem_addr", 32'(bus.mem_addr), 32'h20);
    applyStimulus();
    @(negedge clk);
    checkOutput("hold.d_rdata", bus.d_rdata, ref_mem[8]);
    applyStimulus(); bus.d_req = 1'b0;

    // Reset during an ISSUE_D write aborts it; request right after reset is served.
    applyStimulus(); setData(1'b1, 1'b1, 8'h30, 32'h12345678);
    applyStimulus(); rst = 1'b1;
    @(negedge clk);
    checkOutput("abort.mem_we", 32'(bus.mem_we), 0);
    checkOutput("abort.mem_en", 32'(bus.mem_en), 0);
    applyStimulus(); rst = 1'b0; setData(1'b1, 1'b0, 8'h30, 32'h0);
    @(negedge clk);
    checkQuiet("abort.after");
    checkOutput("abort.after.stall", 32'(bus.stall), 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("abort.rd.mem_en", 32'(bus.mem_en), 1);
    checkOutput("abort.rd.mem_addr", 32'(bus.mem_addr), 32'h30);
    applyStimulus();
    @(negedge clk);
    checkOutput("abort.rd.d_valid", 32'(bus.d_valid), 1);
    checkOutput("abort.rd.d_rdata", bus.d_rdata, ref_mem[12]);
    applyStimulus(); bus.d_req = 1'b0;

    // Request dropped during ISSUE_D still completes once, without reissue.
    applyStimulus(); setData(1'b1, 1'b0, 8'h10, 32'h0);
    applyStimulus(); bus.d_req = 1'b0;
    @(negedge clk);
    checkOutput("drop.mem_en", 32'(bus.mem_en), 1);
    applyStimulus();
    @(negedge clk);
    checkOutput("drop.d_valid", 32'(bus.d_valid), 1);
    checkOutput("drop.d_rdata", bus.d_rdata, ref_mem[4]);
    for (int k = 0; k < 2; k++) begin
      applyStimulus();
      @(negedge clk);
      checkOutput("drop.after.d_valid", 32'(bus.d_valid), 0);
      checkOutput("drop.after.mem_en", 32'(bus.mem_en), 0);
    end

    // Randomized requesters; each completed access is checked against ref_mem.
    if_busy = 1'b0; d_busy = 1'b0; if_done = 1'b0; d_done = 1'b0;
    if_age = 0; d_age = 0; if_a = '0; d_a = '0; d_w = 1'b0; d_wd = '0;
    for (int c = 0; c < 400; c++) begin
      applyStimulus();
      if (if_done) if_busy = 1'b0;
      if (if_busy) if_age++;
      else if ($urandom_range(0, 2) != 0) begin
        if_busy = 1'b1; if_age = 0;
        if_a = {2'b00, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (d_done) d_busy = 1'b0;
      if (d_busy) d_age++;
      else if ($urandom_range(0, 2) != 0) begin
        d_busy = 1'b1; d_age = 0;
        d_a  = {2'b00, 4'($urandom_range(0, 15)), 2'b00};
        d_w  = 1'($urandom_range(0, 1));
        d_wd = $urandom;
      end
      bus.if_req = if_busy; bus.if_addr = if_a;
      setData(d_busy, d_w, d_a, d_wd);

      @(negedge clk);
      if_done = 1'b0; d_done = 1'b0;
      checkOutput("rand.one_valid", 32'(bus.if_valid & bus.d_valid), 0);
      checkOutput("rand.stall", 32'(bus.stall),
                  32'((if_busy & ~bus.if_valid) | (d_busy & ~bus.d_valid)));
      if (bus.mem_we) begin
        checkOutput("rand.we_owner", 32'(d_busy & d_w), 1);
        checkOutput("rand.we_addr", 32'(bus.mem_addr), 32'(d_a));
        checkOutput("rand.we_data", bus.mem_wdata, d_wd);
      end
      if (bus.if_valid) begin
        checkOutput("rand.if_owner", 32'(if_busy), 1);
        checkOutput("rand.if_rdata", bus.if_rdata, ref_mem[if_a[7:2]]);
        checkOutput("rand.if_latency", 32'(if_age <= 4), 1);
        if_done = 1'b1;
      end else begin
        checkOutput("rand.if_rdata_idle", bus.if_rdata, 0);
      end
      if (bus.d_valid) begin
        checkOutput("rand.d_owner", 32'(d_busy), 1);
        checkOutput("rand.d_latency", 32'(d_age <= 4), 1);
        if (d_w) begin
          checkOutput("rand.d_wr_rdata", bus.d_rdata, 0);
          ref_mem[d_a[7:2]] = d_wd;
        end else begin
          checkOutput("rand.d_rd_rdata", bus.d_rdata, ref_mem[d_a[7:2]]);
        end
        d_done = 1'b1;
      end else begin
        checkOutput("rand.d_rdata_idle", bus.d_rdata, 0);
      end
      if (if_busy && if_age > 6) begin
        checkOutput("rand.if_timeout", 32'(if_age), 4);
        if_done = 1'b1;
      end
      if (d_busy && d_age > 6) begin
        checkOutput("rand.d_timeout", 32'(d_age), 4);
        d_done = 1'b1;
      end
    end

    applyStimulus(); bus.if_req = 1'b0; bus.d_req = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
